// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: load/store data-memory access sequencer.
// Accepts single-cycle ld/sd requests with a word-aligned byte address, runs a
// req/gnt/rvalid handshake with data memory, returns load data and holds the
// pipeline stalled while an access is in flight.
// Optional feature macro: LSU_TIMEOUT_EN (aborts accesses stuck in REQ/WAIT
// for TIMEOUT_CYCLES cycles and reports bus_err).
`timescale 1ns/1ps

module lsu_mem_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  addr_clk,
    input  logic                  addr_rst,
    input  logic                  ld_valid,
    input  logic                  sd_valid,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_data_valid,
    output logic                  misalign_exc,
    output logic                  bus_err,
    output logic                  stall_pipeline
);

    if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("lsu_mem_sequencer: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, ld_data_q;
    logic                  we_q, ld_data_valid_q, misalign_q;
    logic                  req_in, aligned, accept, reject;
    logic                  st_done, ld_done, timeout_hit;

    // Request qualification and completion events (only meaningful in their own state)
    assign req_in  = ld_valid | sd_valid;
    assign aligned = (addr[1:0] == 2'b00);
    assign accept  = (state == IDLE) && req_in && aligned;
    assign reject  = (state == IDLE) && req_in && !aligned;
    assign st_done = (state == REQ) && mem_gnt && we_q;
    assign ld_done = (state == WAIT) && mem_rvalid;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] tmo_cnt;
    logic             bus_err_q;

    // Expiry on the last allowed REQ/WAIT cycle; a completion in that same cycle wins
    assign timeout_hit = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                         && !st_done && !ld_done;

    // Cycle counter: cleared when an access is accepted, counts every REQ/WAIT cycle
    always_ff @(posedge addr_clk or negedge addr_rst) begin
        if (!addr_rst) begin
            tmo_cnt   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout_hit;
            if (accept)
                tmo_cnt <= '0;
            else if (state != IDLE)
                tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // State register
    always_ff @(posedge addr_clk or negedge addr_rst) begin
        if (!addr_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state: stores finish at grant, loads finish at rvalid
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ: begin
                if (timeout_hit)  state_nxt = IDLE;
                else if (mem_gnt) state_nxt = we_q ? IDLE : WAIT;
            end
            WAIT: if (ld_done || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, load-data return and single-cycle status pulses
    always_ff @(posedge addr_clk or negedge addr_rst) begin
        if (!addr_rst) begin
            addr_q          <= '0;
            wdata_q         <= '0;
            we_q            <= 1'b0;
            ld_data_q       <= '0;
            ld_data_valid_q <= 1'b0;
            misalign_q      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= st_data;
                we_q    <= sd_valid & ~ld_valid;   // load wins when both arrive
            end
            ld_data_valid_q <= ld_done;
            misalign_q      <= reject;
            if (ld_done)
                ld_data_q <= mem_rdata;
            else if (timeout_hit)
                ld_data_q <= '0;
        end
    end

    // All outputs come straight from registers; no comb path from mem_* inputs
    assign mem_req        = (state == REQ);
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign ld_data        = ld_data_q;
    assign ld_data_valid  = ld_data_valid_q;
    assign misalign_exc   = misalign_q;
    assign stall_pipeline = (state != IDLE);

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: cycle vector table plus hand-written sequences
// for delayed grant, timeout/indefinite wait and async reset mid-access.
// Load results go through a scoreboard queue popped on ld_data_valid.
`timescale 1ns/1ps

module tb_lsu_mem_sequencer;

    logic        addr_clk = 1'b0;
    logic        addr_rst = 1'b0;
    logic        ld_valid = 1'b0, sd_valid = 1'b0;
    logic [31:0] addr = '0, st_data = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ld_data;
    logic        ld_data_valid, misalign_exc, bus_err, stall_pipeline;

    always #5 addr_clk = ~addr_clk;

    lsu_mem_sequencer #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .addr_clk      (addr_clk),
        .addr_rst      (addr_rst),
        .ld_valid      (ld_valid),
        .sd_valid      (sd_valid),
        .addr          (addr),
        .st_data       (st_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .ld_data       (ld_data),
        .ld_data_valid (ld_data_valid),
        .misalign_exc  (misalign_exc),
        .bus_err       (bus_err),
        .stall_pipeline(stall_pipeline)
    );

    typedef struct {
        logic        ld, sd;
        logic [31:0] addr, sdat;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        req, we, stall, ldv, mis, push;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_ld[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock; sample 1ns after the edge and retire any returned load
    task automatic tick();
        logic [31:0] e;
        @(posedge addr_clk);
        #1;
        if (ld_data_valid) begin
            if (exp_ld.size() == 0)
                chk("sb_unexpected_ldv", 32'(ld_data_valid), 32'd0);
            else begin
                e = exp_ld.pop_front();
                chk("sb_ld_data", ld_data, e);
            end
        end
    endtask

    function automatic vec_t mk(input logic ld, sd, input logic [31:0] a, sdat,
                                input logic gnt, rv, input logic [31:0] rd,
                                input logic req, we, stall, ldv, mis, push);
        vec_t v;
        v.ld = ld; v.sd = sd; v.addr = a; v.sdat = sdat; v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.req = req; v.we = we; v.stall = stall; v.ldv = ldv; v.mis = mis; v.push = push;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[16];
        logic        idle_exp;
        logic [31:0] cur_addr, cur_wdata, last_ld;

        // Inputs applied for one cycle; expectations are the registered outputs after that edge
        //             ld sd addr          sdat          gnt rv rd            req we st ldv mis push
        vt[0]  = mk(1, 0, 32'h100, 32'h0,          0, 0, 32'h0,        1, 0, 1, 0, 0, 0);
        vt[1]  = mk(0, 0, 32'h0,   32'h0,          1, 0, 32'h0,        0, 0, 1, 0, 0, 0);
        vt[2]  = mk(0, 0, 32'h0,   32'h0,          0, 1, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1);
        vt[3]  = mk(0, 0, 32'h0,   32'h0,          0, 0, 32'h0,        0, 0, 0, 0, 0, 0);
        vt[4]  = mk(1, 0, 32'h102, 32'h0,          0, 0, 32'h0,        0, 0, 0, 0, 1, 0);
        vt[5]  = mk(0, 0, 32'h0,   32'h0,          0, 0, 32'h0,        0, 0, 0, 0, 0, 0);
        vt[6]  = mk(0, 1, 32'h8,   32'hA5A50001,   1, 0, 32'h0,        1, 1, 1, 0, 0, 0);
        vt[7]  = mk(0, 0, 32'h0,   32'h0,          1, 0, 32'h0,        0, 1, 0, 0, 0, 0);
        vt[8]  = mk(1, 1, 32'h40,  32'hFFFF0000,   0, 1, 32'h11,       1, 0, 1, 0, 0, 0);
        vt[9]  = mk(0, 0, 32'h0,   32'h0,          0, 1, 32'h22,       1, 0, 1, 0, 0, 0);
        vt[10] = mk(0, 1, 32'h80,  32'h9,          1, 0, 32'h0,        0, 0, 1, 0, 0, 0);
        vt[11] = mk(0, 1, 32'h84,  32'h9,          0, 0, 32'h0,        0, 0, 1, 0, 0, 0);
        vt[12] = mk(0, 0, 32'h0,   32'h0,          0, 1, 32'hCAFEF00D, 0, 0, 0, 1, 0, 1);
        vt[13] = mk(0, 0, 32'h0,   32'h0,          0, 0, 32'h0,        0, 0, 0, 0, 0, 0);
        vt[14] = mk(0, 1, 32'h3,   32'h1,          0, 0, 32'h0,        0, 0, 0, 0, 1, 0);
        vt[15] = mk(0, 0, 32'h0,   32'h0,          0, 0, 32'h0,        0, 0, 0, 0, 0, 0);

        idle_exp  = 1'b1;
        cur_addr  = '0;
        cur_wdata = '0;
        last_ld   = '0;

        // Reset state
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_flags", {28'd0, ld_data_valid, misalign_exc, bus_err, stall_pipeline}, 32'd0);
        #10 addr_rst = 1'b1;

        // Table-driven single-cycle behaviour
        for (int i = 0; i < 16; i++) begin
            ld_valid = vt[i].ld;  sd_valid = vt[i].sd;
            addr = vt[i].addr;    st_data = vt[i].sdat;
            mem_gnt = vt[i].gnt;  mem_rvalid = vt[i].rv;  mem_rdata = vt[i].rd;
            if (idle_exp && (vt[i].ld || vt[i].sd) && (vt[i].addr[1:0] == 2'b00)) begin
                cur_addr  = vt[i].addr;
                cur_wdata = vt[i].sdat;
            end
            if (vt[i].push) begin
                exp_ld.push_back(vt[i].rd);
                last_ld = vt[i].rd;
            end
            tick();
            chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(vt[i].req));
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vt[i].we));
            chk($sformatf("v%0d_stall", i), 32'(stall_pipeline), 32'(vt[i].stall));
            chk($sformatf("v%0d_ldv", i), 32'(ld_data_valid), 32'(vt[i].ldv));
            chk($sformatf("v%0d_mis", i), 32'(misalign_exc), 32'(vt[i].mis));
            chk($sformatf("v%0d_berr", i), 32'(bus_err), 32'd0);
            chk($sformatf("v%0d_ld_data", i), ld_data, last_ld);
            if (vt[i].req) begin
                chk($sformatf("v%0d_addr", i), mem_addr, cur_addr);
                if (vt[i].we) chk($sformatf("v%0d_wdata", i), mem_wdata, cur_wdata);
            end
            idle_exp = !vt[i].stall;
        end
        ld_valid = 0; sd_valid = 0; mem_gnt = 0; mem_rvalid = 0;

        // Store with grant delayed 3 cycles: request and payload held steady
        sd_valid = 1; addr = 32'h204; st_data = 32'h12345678;
        tick();
        sd_valid = 0; addr = 32'hFFFFFFF0; st_data = 32'h0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dg%0d_req", k), 32'(mem_req), 32'd1);
            chk($sformatf("dg%0d_we", k), 32'(mem_we), 32'd1);
            chk($sformatf("dg%0d_addr", k), mem_addr, 32'h204);
            chk($sformatf("dg%0d_wdata", k), mem_wdata, 32'h12345678);
            mem_gnt = (k == 3);
            tick();
        end
        mem_gnt = 0;
        chk("dg_done_req", 32'(mem_req), 32'd0);
        chk("dg_done_stall", 32'(stall_pipeline), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // Grant never comes: abort after 16 REQ cycles with bus_err and cleared ld_data
        ld_valid = 1; addr = 32'h400;
        tick();
        ld_valid = 0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("to%0d_stall", k), 32'(stall_pipeline), 32'd1);
            chk($sformatf("to%0d_berr", k), 32'(bus_err), 32'd0);
            tick();
        end
        chk("to_berr", 32'(bus_err), 32'd1);
        chk("to_stall", 32'(stall_pipeline), 32'd0);
        chk("to_ld_data", ld_data, 32'd0);
        chk("to_ldv", 32'(ld_data_valid), 32'd0);
        tick();
        chk("to_berr_pulse", 32'(bus_err), 32'd0);

        // Store granted on the expiry cycle completes without bus_err
        sd_valid = 1; addr = 32'h500; st_data = 32'h7;
        tick();
        sd_valid = 0;
        for (int k = 0; k < 15; k++) tick();
        chk("tx_pre_stall", 32'(stall_pipeline), 32'd1);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        chk("tx_berr", 32'(bus_err), 32'd0);
        chk("tx_stall", 32'(stall_pipeline), 32'd0);
        tick();
        chk("tx_berr_late", 32'(bus_err), 32'd0);
`else
        // Without timeout the request waits indefinitely for its grant
        ld_valid = 1; addr = 32'h400;
        tick();
        ld_valid = 0;
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("nt%0d_req", k), 32'(mem_req), 32'd1);
            chk($sformatf("nt%0d_berr", k), 32'(bus_err), 32'd0);
            tick();
        end
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        mem_rvalid = 1; mem_rdata = 32'h13579BDF;
        exp_ld.push_back(32'h13579BDF);
        tick();
        mem_rvalid = 0;
        chk("nt_ldv", 32'(ld_data_valid), 32'd1);
        chk("nt_ld_data", ld_data, 32'h13579BDF);
`endif

        // Async reset while in WAIT; later stray rvalid must be ignored
        ld_valid = 1; addr = 32'h300;
        tick();
        ld_valid = 0; mem_gnt = 1;
        tick();
        mem_gnt = 0;
        chk("ar_wait_stall", 32'(stall_pipeline), 32'd1);
        #2 addr_rst = 1'b0;
        #1;
        chk("ar_req", 32'(mem_req), 32'd0);
        chk("ar_stall", 32'(stall_pipeline), 32'd0);
        chk("ar_ld_data", ld_data, 32'd0);
        chk("ar_addr", mem_addr, 32'd0);
        tick();
        #1 addr_rst = 1'b1;
        mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
        tick();
        mem_rvalid = 0;
        chk("ar_stray_ldv", 32'(ld_data_valid), 32'd0);
        chk("ar_stray_ld_data", ld_data, 32'd0);
        chk("ar_stray_stall", 32'(stall_pipeline), 32'd0);

        // Normal load after recovery
        ld_valid = 1; addr = 32'h404;
        tick();
        ld_valid = 0; mem_gnt = 1;
        chk("rl_addr", mem_addr, 32'h404);
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
        exp_ld.push_back(32'h0BADF00D);
        tick();
        mem_rvalid = 0;
        chk("rl_ldv", 32'(ld_data_valid), 32'd1);
        chk("rl_ld_data", ld_data, 32'h0BADF00D);
        tick();
        chk("rl_ldv_pulse", 32'(ld_data_valid), 32'd0);

        chk("sb_drained", exp_ld.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
